// File: rtl/toggle_pkg.sv
// Shared types and default parameters for the toggle burst generator.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_AUTO_LEN = 14;

endpackage

// File: rtl/toggle_cnt.sv
// Loadable down-counter tracking how many toggles remain in the current burst.
module toggle_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    // Load has priority over decrement; decrement saturates at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/toggle_burst_gen.sv
// Drives a line that inverts every clock for a programmed number of cycles, then holds.
module toggle_burst_gen
    import toggle_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int AUTO_LEN   = DEF_AUTO_LEN,
    parameter bit AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             a,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    state_t           state;
    state_t           state_n;
    logic             rst_q;
    logic             a_n;
    logic             busy_n;
    logic             done_n;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             auto_start;
    logic             take_start;
    logic [CNT_W-1:0] start_len;

    toggle_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (remaining),
        .zero     (cnt_zero)
    );

    // Reset release acts as a start with the built-in length, and it outranks an external start.
    assign auto_start = AUTO_START && rst_q && !rst;
    assign take_start = auto_start || (start && !busy);
    assign start_len  = auto_start ? CNT_W'(AUTO_LEN) : len;

    // State register plus the registered outputs, all returning to idle values on reset.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state <= IDLE;
            a     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state logic; a start accepted in the done cycle toggles immediately so back-to-back bursts never pause the line.
    always_comb begin
        state_n      = state;
        a_n          = a;
        busy_n       = busy;
        done_n       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (take_start) begin
                    busy_n = 1'b1;
                    if (start_len == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n      = RUN;
                        cnt_load     = 1'b1;
                        cnt_load_val = start_len;
                    end
                end
            end
            RUN: begin
                a_n     = ~a;
                cnt_dec = 1'b1;
                if (remaining == CNT_W'(1) || cnt_zero) begin
                    state_n = FIN;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            FIN: begin
                if (busy) begin
                    busy_n = 1'b0;
                    done_n = 1'b1;
                end else if (take_start) begin
                    if (start_len == '0) begin
                        busy_n = 1'b1;
                    end else if (start_len == CNT_W'(1)) begin
                        a_n          = ~a;
                        cnt_load     = 1'b1;
                        cnt_load_val = '0;
                        busy_n       = 1'b0;
                        done_n       = 1'b1;
                    end else begin
                        state_n      = RUN;
                        a_n          = ~a;
                        cnt_load     = 1'b1;
                        cnt_load_val = start_len - CNT_W'(1);
                        busy_n       = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_toggle_burst_gen.sv
// Directed self-checking bench for toggle_burst_gen with hand-computed expectations.
module tb_toggle_burst_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       a;
    logic       busy;
    logic       done;
    logic [7:0] remaining;

    int vectors;
    int miscompares;

    toggle_burst_gen #(
        .CNT_W      (8),
        .AUTO_LEN   (14),
        .AUTO_START (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [7:0] l);
        rst   = r;
        start = s;
        len   = l;
    endtask

    task automatic checkOutput(input string tag, input logic exp_a, input logic exp_busy,
                               input logic exp_done, input logic [7:0] exp_rem);
        vectors++;
        assert (a === exp_a) else begin
            miscompares++;
            $error("[TB] FAIL %s a: observed %0b expected %0b", tag, a, exp_a);
        end
        vectors++;
        assert (busy === exp_busy) else begin
            miscompares++;
            $error("[TB] FAIL %s busy: observed %0b expected %0b", tag, busy, exp_busy);
        end
        vectors++;
        assert (done === exp_done) else begin
            miscompares++;
            $error("[TB] FAIL %s done: observed %0b expected %0b", tag, done, exp_done);
        end
        vectors++;
        assert (remaining === exp_rem) else begin
            miscompares++;
            $error("[TB] FAIL %s remaining: observed %0d expected %0d", tag, remaining, exp_rem);
        end
    endtask

    initial begin
        int done_count;
        vectors     = 0;
        miscompares = 0;

        // Reset held for five cycles: no burst may start while it is high.
        applyStimulus(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 8'd0);

        // Release: automatic burst of 14 toggles starting from 0.
        $display("[TB] auto start burst");
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("auto_load", 1'b0, 1'b1, 1'b0, 8'd14);
        done_count = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (done) done_count++;
            checkOutput($sformatf("auto_t%0d", i), 1'(i % 2), (i < 14), (i == 14), 8'(14 - i));
        end
        tick();
        if (done) done_count++;
        checkOutput("auto_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        vectors++;
        assert (done_count === 1) else begin
            miscompares++;
            $error("[TB] FAIL auto_done_count: observed %0d expected 1", done_count);
        end

        // Explicit start, length 3: ends inverted at 1.
        $display("[TB] explicit start len=3");
        applyStimulus(1'b0, 1'b1, 8'd3);
        tick();
        checkOutput("len3_load", 1'b0, 1'b1, 1'b0, 8'd3);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("len3_t1", 1'b1, 1'b1, 1'b0, 8'd2);
        tick();
        checkOutput("len3_t2", 1'b0, 1'b1, 1'b0, 8'd1);
        tick();
        checkOutput("len3_t3", 1'b1, 1'b0, 1'b1, 8'd0);
        tick();
        checkOutput("len3_idle", 1'b1, 1'b0, 1'b0, 8'd0);

        // Zero length: busy one cycle, then done, line unchanged.
        $display("[TB] zero length start");
        applyStimulus(1'b0, 1'b1, 8'd0);
        tick();
        checkOutput("len0_busy", 1'b1, 1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("len0_done", 1'b1, 1'b0, 1'b1, 8'd0);
        tick();
        checkOutput("len0_idle", 1'b1, 1'b0, 1'b0, 8'd0);

        // Burst of 5 with a start of length 9 asserted mid-burst, which must be ignored.
        $display("[TB] ignored start mid-burst");
        applyStimulus(1'b0, 1'b1, 8'd5);
        tick();
        checkOutput("ign_load", 1'b1, 1'b1, 1'b0, 8'd5);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("ign_t1", 1'b0, 1'b1, 1'b0, 8'd4);
        applyStimulus(1'b0, 1'b1, 8'd9);
        tick();
        checkOutput("ign_t2", 1'b1, 1'b1, 1'b0, 8'd3);
        tick();
        checkOutput("ign_t3", 1'b0, 1'b1, 1'b0, 8'd2);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("ign_t4", 1'b1, 1'b1, 1'b0, 8'd1);
        tick();
        checkOutput("ign_t5", 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        checkOutput("ign_idle1", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("ign_idle2", 1'b0, 1'b0, 1'b0, 8'd0);

        // Back-to-back bursts of 4: eight continuous toggles, done four cycles apart.
        $display("[TB] back-to-back bursts");
        applyStimulus(1'b0, 1'b1, 8'd4);
        tick();
        checkOutput("b2b_load", 1'b0, 1'b1, 1'b0, 8'd4);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("b2b_t1", 1'b1, 1'b1, 1'b0, 8'd3);
        tick();
        checkOutput("b2b_t2", 1'b0, 1'b1, 1'b0, 8'd2);
        tick();
        checkOutput("b2b_t3", 1'b1, 1'b1, 1'b0, 8'd1);
        tick();
        checkOutput("b2b_t4", 1'b0, 1'b0, 1'b1, 8'd0);
        applyStimulus(1'b0, 1'b1, 8'd4);
        tick();
        checkOutput("b2b_t5", 1'b1, 1'b1, 1'b0, 8'd3);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("b2b_t6", 1'b0, 1'b1, 1'b0, 8'd2);
        tick();
        checkOutput("b2b_t7", 1'b1, 1'b1, 1'b0, 8'd1);
        tick();
        checkOutput("b2b_t8", 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        checkOutput("b2b_idle", 1'b0, 1'b0, 1'b0, 8'd0);

        // Reset mid-run after five toggles, then a fresh auto burst that outranks an external start.
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b0, 8'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("mid_load", 1'b0, 1'b1, 1'b0, 8'd14);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("mid_t%0d", i), 1'(i % 2), 1'b1, 1'b0, 8'(14 - i));
        end
        applyStimulus(1'b1, 1'b0, 8'd0);
        tick();
        checkOutput("mid_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b1, 8'd2);
        tick();
        checkOutput("rel_load", 1'b0, 1'b1, 1'b0, 8'd14);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("rel_t1", 1'b1, 1'b1, 1'b0, 8'd13);
        tick();
        checkOutput("rel_t2", 1'b0, 1'b1, 1'b0, 8'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/toggle_burst_gen.md
# toggle_burst_gen

Stimulus generator that drives a single-bit line `a` which inverts on every clock for a programmed number of cycles, then stops. It sits directly upstream of the toggle-checking property stage, which requires `a == !$past(a)` from the cycle after reset release. It starts automatically on reset release, and can also be restarted by a `start` pulse with a run-time length. Outputs are registered, so the downstream checker sees clean, cycle-exact toggling.

## Interface
- `CNT_W`, 8: width of the length/remaining counter.
- `AUTO_LEN`, 14: toggle count used for the automatic burst on reset release.
- `AUTO_START`, 1: 1 = treat reset release as a start; 0 = wait for `start`.

- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  burst request, sampled only when `busy==0`.
- `len`  in  CNT_W  number of toggles for a `start` burst, captured with `start`.
- `a`  out  1  toggling output.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at end of burst.
- `remaining`  out  CNT_W  toggles still to be produced.

## Operation
- States: IDLE, RUN, FIN.
- Reset: state=IDLE, `a`=0, `busy`=0, `done`=0, `remaining`=0. An internal `rst_q` records the previous value of `rst`.
- Auto start: when AUTO_START=1, `rst_q==1 && rst==0` at an edge acts as `start` with `len=AUTO_LEN`.
- In IDLE or FIN, a start at edge k captures the length:
  - len>0: go to RUN, `remaining=len`, `busy=1`.
  - len=0: go to FIN, `busy=1`, no toggles.
- In RUN:
  - Each edge inverts `a` and decrements `remaining`.
  - The edge that brings `remaining` to 0 enters FIN.
- FIN is one cycle: `busy=0`, `done=1`, `a` held. The next state is IDLE, or RUN/FIN if a start is sampled in this cycle.
- `a` holds its last value between bursts. The next burst toggles from that value, with no return-to-zero.
- `start` is ignored while `busy==1`. `len` changes during a burst are ignored.
- If auto start and an external `start` coincide, the auto start wins (AUTO_LEN).

## Timing
- Start sampled at edge k (any length L ≥ 1):
  - `busy=1` after edges k .. k+L−1.
  - `a` toggles after edges k+1 .. k+L, giving exactly L toggles.
  - `done=1` and `busy=0` after edge k+L.
- L=0: `busy=1` after edge k, `done=1` after edge k+1, `a` unchanged.
- Back-to-back bursts: `start` asserted during the `done` cycle (edge k+L) makes the first toggle of the next burst land after edge k+L+1. `a` keeps toggling with no gap.
- Reset mid-burst: the outputs return to their reset values after the edge where `rst` is sampled high. The burst is abandoned with no `done`. Release then triggers a fresh auto burst if AUTO_START=1.
- Reset held high for several cycles triggers only one auto start, on the falling edge.
- `remaining` equals L minus the toggles already produced. The counter does not wrap; the decrement is gated at 0.

## Structure
- Package `toggle_pkg`:
  - `state_t` enum {IDLE, RUN, FIN}.
  - Localparams for the default CNT_W and AUTO_LEN.
- One sub-module, `toggle_cnt`: a loadable down-counter with inputs `load`, `load_val`, `dec` and a `zero` flag.
- The FSM, the auto-start edge detector and the `a` register live in the top module.

## Test plan
- Auto start: rst high 5 cycles then low, AUTO_LEN=14 → `a` = 1,0,1,… for 14 cycles. `a == !$past(a)` holds for 14 consecutive cycles, `done` pulses once, and `a` ends at 0.
- Explicit start: after idle, `start=1`, `len=3` → `a` toggles 3 times, ending inverted. `remaining` reads 3,2,1,0, and `done` asserts on the cycle `remaining` hits 0.
- Zero length: `start`, `len=0` → `busy` high 1 cycle, `done` on the next cycle, `a` unchanged.
- Ignored start: a `start` with `len=9` mid-burst of 5 → exactly 5 toggles, a single `done`, and no extra burst.
- Back-to-back: `start` `len=4` again in the `done` cycle → 8 continuous toggles, with `done` pulses 4 cycles apart.
- Reset mid-run: `rst` high after the 5th of 14 toggles → the next cycle shows `a=0`, `busy=0`, `done=0`. Release then starts a fresh 14-toggle burst.
